fetch_pc_unit: RTL
==================

Name: fetch_pc_unit

Overview:
Parametrised successor to the single PC register: it owns the fetch PC and drives the instruction-memory request/response handshake. It arbitrates several prioritised redirect sources and discards stale responses after a redirect. It also buffers one fetched instruction toward decode under a valid/ready handshake. It sits at the head of the pipeline, between the redirect sources (exception/commit, EX branch, ID jump) and the F/D pipeline register.

Parameters:
XLEN, 64, PC width in bits
ILEN, 32, instruction width in bits
PC_INIT, 64'h8000_0000, PC value loaded on reset
STEP, 4, sequential PC increment in bytes
NREDIR, 3, number of redirect channels; index 0 has the highest priority

Ports:
clk  in  1  clock
reset  in  1  reset, synchronous, active-high
redir_valid  in  NREDIR  per-channel redirect request
redir_pc  in  NREDIR*XLEN  per-channel target; channel i occupies bits [i*XLEN +: XLEN]
ireq_valid  out  1  fetch request valid
ireq_addr  out  XLEN  fetch address (always equal to the pc register)
ireq_ready  in  1  memory accepts the request this cycle
iresp_valid  in  1  response valid; earliest one cycle after acceptance
iresp_data  in  ILEN  fetched instruction
out_valid  out  1  instruction available to decode
out_pc  out  XLEN  PC of the buffered instruction
out_instr  out  ILEN  buffered instruction
out_ready  in  1  decode accepts the instruction

Behaviour:
- State: pc (XLEN), st in {REQ, WAIT, OUT}, kill (1), ibuf (ILEN).
- Reset: pc=PC_INIT, st=REQ, kill=0, ibuf=0. On the reset cycle itself, ireq_valid=0 and out_valid=0. In the first cycle after reset deasserts, ireq_valid=1 with ireq_addr=PC_INIT.
- redir = OR of redir_valid. The target is redir_pc of the lowest-indexed asserted channel; other channels are ignored that cycle.
- ireq_valid = (st==REQ) & ~reset.
- out_valid = (st==OUT) & ~redir. A redirect masks the output combinationally in the same cycle.
- out_pc = pc while st==OUT. out_instr = ibuf.
- REQ:
  - redir & ~ireq_ready: pc<=target, stay REQ. Abandoning an unaccepted request is legal on this bus.
  - redir & ireq_ready: the old address counts as accepted. pc<=target, kill<=1, go to WAIT.
  - ireq_ready only: go to WAIT.
  - otherwise: hold.
- WAIT:
  - iresp_valid & (kill | redir): drop the response, kill<=0, go to REQ. If redir, pc<=target.
  - iresp_valid & ~kill & ~redir: ibuf<=iresp_data, go to OUT.
  - redir & ~iresp_valid: pc<=target, kill<=1, stay WAIT.
  - Repeated redirects while waiting overwrite pc. Only one request is ever outstanding, so a single kill bit suffices.
- OUT:
  - redir: pc<=target, go to REQ. No transfer happens, because out_valid is masked.
  - out_ready: pc<=pc+STEP (modulo 2^XLEN, wraps silently), go to REQ.
  - otherwise: hold. out_pc and out_instr stay stable.
- Priority within a cycle: reset > redirect > handshake events.
- Best-case throughput: one instruction per 3 cycles with single-cycle memory. Redirect-to-request latency is 1 cycle, except in WAIT, where it waits for the outstanding response.
- Reset mid-operation from any state returns to reset values. The memory is reset by the same signal, so no pre-reset response arrives afterward.
- Misaligned targets are passed through unchanged; alignment faults are detected downstream.

Decomposition:
- Shared package (pipes): fetch_state_t enum {REQ, WAIT, OUT}; default PC_INIT constant; u64/u32 typedefs (common).
- One natural sub-module: redirect_arb.
  - Parametrised by NREDIR and XLEN.
  - Combinational fixed-priority select producing any_valid and target.
  - Keeps the FSM file free of the priority loop.

Test Plan:
- Reset and sequential fetch. Release reset; memory accepts immediately and responds 1 cycle later; out_ready=1. Expect ireq_addr=0x80000000, then out_pc 0x80000000, 0x80000004, 0x80000008, each with the matching iresp_data.
- Redirect while waiting. After accept at 0x80000000, assert redir[1]=0x80001000 in WAIT, then deliver iresp 0xDEAD. Expect 0xDEAD dropped (out_valid never 1 for it) and the next ireq_addr=0x80001000.
- Priority. In REQ, assert redir[2]=0x3000 and redir[0]=0x1000 simultaneously. Expect ireq_addr=0x1000 next cycle.
- Simultaneous accept and redirect in REQ. Assert ireq_ready with redir[0]=0x2000. Expect a WAIT with kill set; the response is discarded and the next request goes to 0x2000.
- Decode backpressure. out_ready=0 for 5 cycles in OUT. Expect out_valid=1 with stable out_pc and out_instr, and ireq_valid=0. When out_ready rises, pc advances by STEP.
- Wrap and mid-op reset. With PC_INIT=64'hFFFF_FFFF_FFFF_FFFC, one fetch gives next ireq_addr=0. Asserting reset in WAIT gives ireq_valid=0 that cycle and ireq_addr=PC_INIT after release.

Source files
------------

// File: rtl/fetch_pc_unit_pkg.sv
// Shared fetch-stage types: FSM state encoding, reset PC default, common word typedefs.
package fetch_pc_unit_pkg;
    typedef logic [63:0] u64;
    typedef logic [31:0] u32;

    localparam u64 PC_INIT_DEFAULT = 64'h8000_0000;

    typedef enum logic [1:0] {
        REQ,
        WAIT,
        OUT
    } fetch_state_t;
endpackage

// File: rtl/fetch_pc_unit_if.sv
// Fetch-stage bundle: redirect inputs, imem request/response, and decode-side output.
interface fetch_pc_unit_if #(
    parameter int XLEN   = 64,
    parameter int ILEN   = 32,
    parameter int NREDIR = 3
);
    logic [NREDIR-1:0]      redir_valid;
    logic [NREDIR*XLEN-1:0] redir_pc;
    logic                   ireq_valid;
    logic [XLEN-1:0]        ireq_addr;
    logic                   ireq_ready;
    logic                   iresp_valid;
    logic [ILEN-1:0]        iresp_data;
    logic                   out_valid;
    logic [XLEN-1:0]        out_pc;
    logic [ILEN-1:0]        out_instr;
    logic                   out_ready;

    modport master (
        input  redir_valid, redir_pc, ireq_ready, iresp_valid, iresp_data, out_ready,
        output ireq_valid, ireq_addr, out_valid, out_pc, out_instr
    );

    modport slave (
        output redir_valid, redir_pc, ireq_ready, iresp_valid, iresp_data, out_ready,
        input  ireq_valid, ireq_addr, out_valid, out_pc, out_instr
    );
endinterface

// File: rtl/fetch_pc_unit_redirect_arb.sv
// Fixed-priority redirect select: channel 0 wins; purely combinational.
module fetch_pc_unit_redirect_arb #(
    parameter int NREDIR = 3,
    parameter int XLEN   = 64
) (
    input  logic [NREDIR-1:0]      i_valid,
    input  logic [NREDIR*XLEN-1:0] i_pc,
    output logic                   o_any_valid,
    output logic [XLEN-1:0]        o_target
);
    always_comb begin
        o_any_valid = |i_valid;
        o_target    = '0;
        // Walk from lowest priority upward so the lowest asserted index overwrites last.
        for (int i = NREDIR - 1; i >= 0; i--) begin
            if (i_valid[i]) begin
                o_target = i_pc[i*XLEN +: XLEN];
            end
        end
    end
endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch PC owner: one outstanding imem request, stale-response kill after redirect,
// single-entry instruction buffer toward decode (one instruction per 3 cycles best case).
module fetch_pc_unit
    import fetch_pc_unit_pkg::*;
#(
    parameter int              XLEN    = 64,
    parameter int              ILEN    = 32,
    parameter logic [XLEN-1:0] PC_INIT = XLEN'(PC_INIT_DEFAULT),
    parameter int              STEP    = 4,
    parameter int              NREDIR  = 3
) (
    input  logic           clk,
    input  logic           reset,
    fetch_pc_unit_if.master bus
);
    fetch_state_t    r_st, w_st_nxt;
    logic [XLEN-1:0] r_pc, w_pc_nxt;
    logic            r_kill, w_kill_nxt;
    logic [ILEN-1:0] r_ibuf, w_ibuf_nxt;

    logic            w_redir;
    logic [XLEN-1:0] w_target;

    fetch_pc_unit_redirect_arb #(
        .NREDIR (NREDIR),
        .XLEN   (XLEN)
    ) u_arb (
        .i_valid     (bus.redir_valid),
        .i_pc        (bus.redir_pc),
        .o_any_valid (w_redir),
        .o_target    (w_target)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_st   <= REQ;
            r_pc   <= PC_INIT;
            r_kill <= 1'b0;
            r_ibuf <= '0;
        end else begin
            r_st   <= w_st_nxt;
            r_pc   <= w_pc_nxt;
            r_kill <= w_kill_nxt;
            r_ibuf <= w_ibuf_nxt;
        end
    end

    always_comb begin
        w_st_nxt   = r_st;
        w_pc_nxt   = r_pc;
        w_kill_nxt = r_kill;
        w_ibuf_nxt = r_ibuf;
        case (r_st)
            REQ: begin
                if (w_redir) begin
                    w_pc_nxt = w_target;
                    // Old address was taken by memory; its response must be dropped.
                    if (bus.ireq_ready) begin
                        w_kill_nxt = 1'b1;
                        w_st_nxt   = WAIT;
                    end
                end else if (bus.ireq_ready) begin
                    w_st_nxt = WAIT;
                end
            end
            WAIT: begin
                if (bus.iresp_valid) begin
                    if (r_kill || w_redir) begin
                        w_kill_nxt = 1'b0;
                        w_st_nxt   = REQ;
                        if (w_redir) begin
                            w_pc_nxt = w_target;
                        end
                    end else begin
                        w_ibuf_nxt = bus.iresp_data;
                        w_st_nxt   = OUT;
                    end
                end else if (w_redir) begin
                    w_pc_nxt   = w_target;
                    w_kill_nxt = 1'b1;
                end
            end
            OUT: begin
                if (w_redir) begin
                    w_pc_nxt = w_target;
                    w_st_nxt = REQ;
                end else if (bus.out_ready) begin
                    w_pc_nxt = r_pc + XLEN'(STEP);
                    w_st_nxt = REQ;
                end
            end
            default: begin
                w_st_nxt = REQ;
            end
        endcase
    end

    assign bus.ireq_valid = (r_st == REQ) && !reset;
    assign bus.ireq_addr  = r_pc;
    assign bus.out_valid  = (r_st == OUT) && !w_redir && !reset;
    assign bus.out_pc     = r_pc;
    assign bus.out_instr  = r_ibuf;
endmodule
